// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and memory (slave).
//
// Handshake: the master raises mem_req together with mem_we/mem_addr/mem_wdata/mem_be and
// holds all of them stable until the slave answers with a single-cycle mem_ack (mem_rdata
// valid in that same cycle) or until the master gives up on a timeout. An ack seen while
// mem_req is low is meaningless and is ignored by the master.
interface mem_access_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one req/ack transaction per load/store, byte-lane
// formatting for stores, sign/zero extension for loads, and a pipeline stall while in flight.
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    MemReadM,
   input  logic                    MemWriteM,
   input  logic [2:0]              funct3M,
   input  logic [31:0]             ALUResultM,
   input  logic [31:0]             WriteDataM,
   mem_access_ctrl_if.master       bus,
   output logic [31:0]             ReadDataM,
   output logic                    StallM,
   output logic                    bus_err,
   output logic                    align_err,
   output logic [1:0]              o_state
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_state;
   logic [CW-1:0] r_cnt;
   logic         r_req;
   logic         r_we;
   logic [31:0]  r_addr;
   logic [31:0]  r_wdata;
   logic [3:0]   r_be;
   logic [2:0]   r_f3;
   logic [1:0]   r_alo;
   logic [31:0]  r_rdata;
   logic         r_bus_err;
   logic         r_align_err;

   logic         w_access;
   logic         w_bad;
   logic [3:0]   w_be;
   logic [31:0]  w_wdata;
   logic [7:0]   w_byte;
   logic [15:0]  w_half;
   logic [31:0]  w_load_ext;

   assign w_access = MemReadM | MemWriteM;

   // Legality of the current MEM-stage access: funct3 must name a size valid for the
   // direction, and halfword/word addresses must be naturally aligned.
   always_comb begin
      w_bad = 1'b1;
      case (funct3M)
         3'b000:  w_bad = 1'b0;
         3'b001:  w_bad = ALUResultM[0];
         3'b010:  w_bad = (ALUResultM[1:0] != 2'b00);
         3'b100:  w_bad = MemWriteM;
         3'b101:  w_bad = MemWriteM | ALUResultM[0];
         default: w_bad = 1'b1;
      endcase
   end

   // Store lane formatting: replicate the narrow datum across the word, enable only its lanes.
   // Loads always fetch the whole word.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = WriteDataM;
      if (!MemReadM) begin
         case (funct3M[1:0])
            2'b00: begin
               w_be    = 4'b0001 << ALUResultM[1:0];
               w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = WriteDataM;
            end
         endcase
      end
   end

   // Load extraction from the returned word using the size/offset latched at issue time.
   always_comb begin
      w_byte     = bus.mem_rdata[8*r_alo +: 8];
      w_half     = bus.mem_rdata[16*r_alo[1] +: 16];
      w_load_ext = bus.mem_rdata;
      case (r_f3)
         3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_ext = {24'd0, w_byte};
         3'b101:  w_load_ext = {16'd0, w_half};
         default: w_load_ext = bus.mem_rdata;
      endcase
   end

   // Transaction FSM: IDLE issues or rejects, BUSY waits for ack or timeout, DONE lets the
   // instruction retire for one unstalled cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_be        <= 4'd0;
         r_f3        <= 3'd0;
         r_alo       <= 2'd0;
         r_rdata     <= 32'd0;
         r_bus_err   <= 1'b0;
         r_align_err <= 1'b0;
      end else begin
         r_bus_err   <= 1'b0;
         r_align_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  if (w_bad) begin
                     r_align_err <= 1'b1;
                     r_rdata     <= 32'd0;
                     r_state     <= S_DONE;
                  end else begin
                     r_req   <= 1'b1;
                     r_we    <= MemWriteM;
                     r_addr  <= {ALUResultM[31:2], 2'b00};
                     r_wdata <= w_wdata;
                     r_be    <= w_be;
                     r_f3    <= funct3M;
                     r_alo   <= ALUResultM[1:0];
                     r_cnt   <= '0;
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               // An ack arriving on the last allowed cycle still counts as success.
               if (bus.mem_ack) begin
                  r_req <= 1'b0;
                  if (!r_we) begin
                     r_rdata <= w_load_ext;
                  end
                  r_state <= S_DONE;
               end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  r_req     <= 1'b0;
                  r_bus_err <= 1'b1;
                  r_rdata   <= 32'd0;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign StallM        = ((r_state == S_IDLE) & w_access) | (r_state == S_BUSY);
   assign bus.mem_req   = r_req;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_be    = r_be;
   assign ReadDataM     = r_rdata;
   assign bus_err       = r_bus_err;
   assign align_err     = r_align_err;
   assign o_state       = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus random loads/stores against a reference model
// derived from access size, offset and extension rules.
module tb_mem_access_ctrl;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        bus_err;
   logic        align_err;
   logic [1:0]  o_state;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_rd;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .bus        (bus.master),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .bus_err    (bus_err),
      .align_err  (align_err),
      .o_state    (o_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit is_bad(input bit wr, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      if (wr) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (!legal) return 1'b1;
      return (a % size_of(f3)) != 0;
   endfunction

   function automatic logic [3:0] be_model(input bit wr, input logic [2:0] f3, input logic [31:0] a);
      int sz;
      if (!wr) return 4'b1111;
      sz = size_of(f3);
      return 4'(((1 << sz) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] w;
      int sz;
      sz = size_of(f3);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rdata);
      int sz;
      logic [31:0] mask;
      logic [31:0] v;
      sz = size_of(f3);
      if (sz == 4) return rdata;
      mask = (32'h1 << (8*sz)) - 32'h1;
      v = (rdata >> (8*(a % 4))) & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- driver ----------------
   // One MEM-stage instruction. d = BUSY cycle index on which memory acks (d<0: never).
   task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int d, input logic [31:0] rdata);
      bit bad;
      bit acked;
      bad = is_bad(wr, f3, a);
      @(negedge clk);
      MemReadM      = rd;
      MemWriteM     = wr;
      funct3M       = f3;
      ALUResultM    = a;
      WriteDataM    = wd;
      bus.mem_ack   = 1'b0;
      #1 check("stall_on_access", StallM, 1);
      @(posedge clk);
      #1;
      if (bad) begin
         exp_rd = 32'd0;
         check("align_err_pulse", align_err, 1);
         check("no_req_on_bad", bus.mem_req, 0);
         check("bus_err_on_bad", bus_err, 0);
         check("stall_done_bad", StallM, 0);
         check("rdata_zero_bad", ReadDataM, exp_rd);
      end else begin
         if (rd) exp_q.push_back(load_model(f3, a, rdata));
         check("req_issue", bus.mem_req, 1);
         check("we", bus.mem_we, wr);
         check("addr", bus.mem_addr, a & 32'hFFFF_FFFC);
         check("be", bus.mem_be, be_model(wr, f3, a));
         if (wr) check("wdata", bus.mem_wdata, wdata_model(f3, wd));
         acked = 1'b0;
         for (int k = 0; k < T; k++) begin
            @(negedge clk);
            bus.mem_ack   = (k == d);
            bus.mem_rdata = (k == d) ? rdata : $urandom;
            #1;
            check("stall_busy", StallM, 1);
            check("req_held", bus.mem_req, 1);
            check("addr_held", bus.mem_addr, a & 32'hFFFF_FFFC);
            @(posedge clk);
            #1;
            if (k == d) begin
               acked = 1'b1;
               break;
            end
         end
         if (rd) begin
            if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
            else if (acked) exp_rd = exp_q.pop_front();
            else void'(exp_q.pop_front());
         end
         if (!acked) exp_rd = 32'd0;
         check("req_drop", bus.mem_req, 0);
         check("bus_err", bus_err, !acked);
         check("align_err_none", align_err, 0);
         check("stall_done", StallM, 0);
         check("readdata", ReadDataM, exp_rd);
      end
      // DONE cycle: instruction retires; a stray ack here must be ignored
      @(negedge clk);
      MemReadM      = 1'b0;
      MemWriteM     = 1'b0;
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      @(posedge clk);
      #1;
      check("pulse_clear_bus", bus_err, 0);
      check("pulse_clear_align", align_err, 0);
      check("idle_no_req", bus.mem_req, 0);
      check("idle_no_stall", StallM, 0);
      check("readdata_hold", ReadDataM, exp_rd);
      @(negedge clk);
      bus.mem_ack = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset         = 1'b1;
      MemReadM      = 1'b0;
      MemWriteM     = 1'b0;
      funct3M       = 3'd0;
      ALUResultM    = 32'd0;
      WriteDataM    = 32'd0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'd0;
      exp_rd        = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", bus.mem_req, 0);
      check("rst_we", bus.mem_we, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_be", bus.mem_be, 0);
      check("rst_rdata", ReadDataM, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_align_err", align_err, 0);
      check("rst_stall", StallM, 0);
      @(negedge clk);
      reset = 1'b0;

      // directed cases
      access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);   // LW, fastest ack
      access(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);   // LW, ack one cycle later
      access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000);  // LB  -> FFFFFF80
      access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000);  // LBU -> 00000080
      access(1, 0, 3'b101, 32'h102, 32'h0, 2, 32'h80FF_0000);  // LHU -> 000080FF
      access(0, 1, 3'b000, 32'h201, 32'h12345678, 1, 32'h0);   // SB lane 1
      access(0, 1, 3'b001, 32'h202, 32'hCAFE_BABE, 0, 32'h0);  // SH upper half
      access(1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0);          // LH misaligned
      access(0, 1, 3'b100, 32'h200, 32'h0, 0, 32'h0);          // SBU illegal
      access(1, 0, 3'b010, 32'h104, 32'h0, T - 1, 32'h1234_5678); // ack on last allowed cycle
      access(1, 0, 3'b010, 32'h108, 32'h0, -1, 32'h0);         // timeout

      // reset in the middle of a transaction
      @(negedge clk);
      MemWriteM  = 1'b1;
      funct3M    = 3'b010;
      ALUResultM = 32'h300;
      WriteDataM = 32'h5555_AAAA;
      @(posedge clk);
      #1 check("rst_mid_req_up", bus.mem_req, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mid_req_drop", bus.mem_req, 0);
      check("rst_mid_bus_err", bus_err, 0);
      MemWriteM = 1'b0;
      exp_rd    = 32'd0;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      access(0, 1, 3'b010, 32'h300, 32'h5555_AAAA, 1, 32'h0);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         bit          rd;
         logic [2:0]  f3;
         logic [31:0] a;
         int          d;
         rd = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
         if ($urandom_range(0, 3) != 0) a[1] = 1'b0;
         d  = $urandom_range(0, T + 1);
         if (d >= T) d = -1;
         access(rd, !rd, f3, a, $urandom, d, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("idle_gap_stall", StallM, 0);
            check("idle_gap_req", bus.mem_req, 0);
            check("idle_gap_rdata", ReadDataM, exp_rd);
            @(negedge clk);
            bus.mem_ack = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
